// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default bit timing
// and the parity helper used by the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    s_IDLE,
    s_TX_START_BIT,
    s_TX_DATA_BITS,
    s_TX_PARITY_BIT,
    s_TX_STOP_BIT,
    s_CLEANUP
  } uart_state_e;

  localparam int CLKS_PER_BIT_DEF = 87;

  function automatic logic parity_bit(
    input logic [7:0] data,
    input logic       odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter.
// A push at full is refused even when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             full, do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge i_Clock) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes sent as start, 8 data (LSB
// first), optional parity and 1-2 stop bits; outputs are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [FAW:0]  FULL_CNT  = (FAW+1)'(FIFO_DEPTH);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);
  localparam logic          PAR_EN    = (PARITY_EN != 0);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          stop_q, stop_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          line_q, line_d;
  logic          active_q, active_d;
  logic          done_q, done_d;

  logic          pop, empty, bit_end;
  logic [7:0]    head;
  logic [FAW:0]  count;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .push_i  (i_Tx_DV),
    .data_i  (i_Tx_Byte),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (empty),
    .count_o (count)
  );

  assign o_Tx_Ready  = (count != FULL_CNT);
  assign o_Tx_Serial = line_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;
  assign bit_end     = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    data_d  = data_q;
    par_d   = par_q;
    pop     = 1'b0;
    unique case (state_q)
      s_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          data_d  = head;
          par_d   = parity_bit(head, PAR_ODD);
          cnt_d   = '0;
          state_d = s_TX_START_BIT;
        end
      end
      s_TX_START_BIT: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = s_TX_DATA_BITS;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      s_TX_DATA_BITS: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = PAR_EN ? s_TX_PARITY_BIT
                             : s_TX_STOP_BIT;
          end else idx_d = idx_q + 3'd1;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      s_TX_PARITY_BIT: begin
        if (bit_end) begin
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = s_TX_STOP_BIT;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      s_TX_STOP_BIT: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop_q == STOP_LAST) state_d = s_CLEANUP;
          else stop_d = 1'b1;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      s_CLEANUP: state_d = s_IDLE;
      default:   state_d = s_IDLE;
    endcase

    // Outputs are registered from the next state so the line
    // changes in the same cycle the state does.
    line_d = 1'b1;
    unique case (state_d)
      s_TX_START_BIT:  line_d = 1'b0;
      s_TX_DATA_BITS:  line_d = data_d[idx_d];
      s_TX_PARITY_BIT: line_d = par_d;
      default:         line_d = 1'b1;
    endcase
    active_d = (state_d inside {s_TX_START_BIT, s_TX_DATA_BITS,
                                s_TX_PARITY_BIT, s_TX_STOP_BIT});
    done_d   = (state_d == s_CLEANUP);
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q  <= s_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      data_q   <= '0;
      par_q    <= 1'b0;
      line_q   <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      data_q   <= data_d;
      par_q    <= par_d;
      line_q   <= line_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations driven in lockstep and
// checked every cycle against a frame-waveform model.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int N     = 4;
  localparam logic [N-1:0] PEN  = 4'b0110;
  localparam logic [N-1:0] PODD = 4'b0100;
  localparam logic [N-1:0] TWO  = 4'b1000;

  typedef struct packed {
    logic line;
    logic active;
    logic done;
    logic idle;
  } ent_t;

  localparam ent_t IDLE_E = 4'b1001;

  logic         clk, rst_n, dv;
  logic [7:0]   byt;
  logic [N-1:0] rdy, ser, act, done;

  ent_t       wq  [N][$];
  ent_t       cur [N];
  logic [7:0] mq  [N][$];
  logic       tr  [N][$];
  logic       dn  [N][$];
  logic [7:0] dec_b [$];
  int         dec_s [$];
  int         nacc  [N];
  int         checks, errors;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
            .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .i_Clock(clk), .i_Reset(rst_n), .i_Tx_DV(dv), .i_Tx_Byte(byt),
    .o_Tx_Ready(rdy[0]), .o_Tx_Serial(ser[0]),
    .o_Tx_Active(act[0]), .o_Tx_Done(done[0]));

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
            .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .i_Clock(clk), .i_Reset(rst_n), .i_Tx_DV(dv), .i_Tx_Byte(byt),
    .o_Tx_Ready(rdy[1]), .o_Tx_Serial(ser[1]),
    .o_Tx_Active(act[1]), .o_Tx_Done(done[1]));

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
            .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .i_Clock(clk), .i_Reset(rst_n), .i_Tx_DV(dv), .i_Tx_Byte(byt),
    .o_Tx_Ready(rdy[2]), .o_Tx_Serial(ser[2]),
    .o_Tx_Active(act[2]), .o_Tx_Done(done[2]));

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
            .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .i_Clock(clk), .i_Reset(rst_n), .i_Tx_DV(dv), .i_Tx_Byte(byt),
    .o_Tx_Ready(rdy[3]), .o_Tx_Serial(ser[3]),
    .o_Tx_Active(act[3]), .o_Tx_Done(done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int i,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %0h want %0h",
               nm, i, $time, got, exp);
    end
  endtask

  // Whole frame as a list of bit values, each held CPB cycles,
  // followed by the single done/cleanup cycle.
  task automatic build(input int i, input logic [7:0] b);
    logic bits [$];
    ent_t e;
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(b[k]);
    if (PEN[i]) bits.push_back((^b) ^ PODD[i]);
    bits.push_back(1'b1);
    if (TWO[i]) bits.push_back(1'b1);
    foreach (bits[k]) begin
      e = '{line: bits[k], active: 1'b1, done: 1'b0, idle: 1'b0};
      repeat (CPB) wq[i].push_back(e);
    end
    e = '{line: 1'b1, active: 1'b0, done: 1'b1, idle: 1'b0};
    wq[i].push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      wq[i].delete();
      cur[i] = IDLE_E;
    end
  endtask

  task automatic model_edge();
    logic p, a;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        p = cur[i].idle && (mq[i].size() > 0);
        a = dv && (mq[i].size() < DEPTH);
        if (p) build(i, mq[i].pop_front());
        if (a) mq[i].push_back(byt);
        cur[i] = (wq[i].size() > 0) ? wq[i].pop_front() : IDLE_E;
      end
    end
  endtask

  task automatic cmp();
    for (int i = 0; i < N; i++) begin
      chk("serial", i, ser[i], cur[i].line);
      chk("active", i, act[i], cur[i].active);
      chk("done",   i, done[i], cur[i].done);
      chk("ready",  i, rdy[i], mq[i].size() < DEPTH);
      tr[i].push_back(ser[i]);
      dn[i].push_back(done[i]);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cmp();
    end
  endtask

  task automatic clear_trace();
    for (int i = 0; i < N; i++) begin
      tr[i].delete();
      dn[i].delete();
    end
  endtask

  function automatic int first_low(input int i);
    foreach (tr[i][j]) if (tr[i][j] == 1'b0) return j;
    return -1;
  endfunction

  function automatic int first_done(input int i);
    foreach (dn[i][j]) if (dn[i][j] == 1'b1) return j;
    return -1;
  endfunction

  function automatic int ones_done(input int i);
    int n = 0;
    foreach (dn[i][j]) if (dn[i][j] == 1'b1) n++;
    return n;
  endfunction

  task automatic decode(input int i, input int flen);
    int j;
    logic [7:0] b;
    dec_b.delete();
    dec_s.delete();
    j = 0;
    while (j + flen < tr[i].size()) begin
      if (tr[i][j] == 1'b0) begin
        for (int k = 0; k < 8; k++)
          b[k] = tr[i][j + CPB + CPB*k + CPB/2];
        dec_b.push_back(b);
        dec_s.push_back(j);
        j += flen;
      end else j++;
    end
  endtask

  initial begin
    int s, d, n;
    logic [9:0] a5_bits;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    dv     = 1'b0;
    byt    = 8'h00;
    model_reset();

    // power-up reset
    step(3);
    for (int i = 0; i < N; i++) begin
      chk("por_serial", i, ser[i], 1'b1);
      chk("por_ready",  i, rdy[i], 1'b1);
      chk("por_active", i, act[i], 1'b0);
      chk("por_done",   i, done[i], 1'b0);
    end
    rst_n = 1'b1;
    step(3);

    // single byte 0xA5
    clear_trace();
    dv  = 1'b1;
    byt = 8'hA5;
    step();
    dv  = 1'b0;
    byt = 8'hFF;
    step(55);
    s = first_low(0);
    d = first_done(0);
    chk("a5_latency", 0, s, 1);
    chk("a5_done_dly", 0, d - s, 40);
    chk("a5_done_cnt", 0, ones_done(0), 1);
    a5_bits = 10'b1101001010;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < CPB; j++)
        chk("a5_wave", 0, tr[0][s + CPB*k + j], a5_bits[k]);
    decode(0, 40);
    chk("a5_nfrm", 0, dec_b.size(), 1);
    if (dec_b.size() > 0) chk("a5_decode", 0, dec_b[0], 8'hA5);
    chk("a5_par_dly", 1, first_done(1) - first_low(1), 44);

    // burst with DV held high
    clear_trace();
    for (int i = 0; i < N; i++) nacc[i] = 0;
    for (int k = 1; k <= 6; k++) begin
      dv  = 1'b1;
      byt = 8'(k);
      for (int i = 0; i < N; i++) if (rdy[i]) nacc[i]++;
      if (k == 6) chk("burst_rdy6", 0, rdy[0], 1'b0);
      step();
    end
    dv = 1'b0;
    chk("burst_acc", 0, nacc[0], 5);
    chk("burst_acc", 3, nacc[3], 5);
    step(250);
    decode(0, 40);
    chk("burst_nfrm", 0, dec_b.size(), 5);
    for (int k = 0; k < dec_b.size(); k++)
      chk("burst_byte", 0, dec_b[k], k + 1);
    for (int k = 1; k < dec_s.size(); k++)
      chk("burst_gap", 0, dec_s[k] - dec_s[k-1], 42);

    // parity on 0x07
    clear_trace();
    dv  = 1'b1;
    byt = 8'h07;
    step();
    dv = 1'b0;
    step(55);
    s = first_low(1);
    chk("par_even", 1, tr[1][s + 9*CPB + CPB/2], 1'b1);
    chk("par_len",  1, first_done(1) - s, 44);
    s = first_low(2);
    chk("par_odd",  2, tr[2][s + 9*CPB + CPB/2], 1'b0);
    chk("par_len",  2, first_done(2) - s, 44);

    // two stop bits on 0x00
    clear_trace();
    dv  = 1'b1;
    byt = 8'h00;
    step();
    dv = 1'b0;
    step(55);
    s = first_low(3);
    n = 0;
    while (s >= 0 && s + n < tr[3].size() && tr[3][s + n] == 1'b0) n++;
    d = first_done(3);
    chk("stop2_low", 3, n, 36);
    chk("stop2_high", 3, d - (s + n), 8);
    chk("stop2_len", 3, d - s, 44);

    // reset during data bit 3, with a second byte queued
    dv  = 1'b1;
    byt = 8'h00;
    step();
    byt = 8'h55;
    step();
    dv = 1'b0;
    step(17);
    chk("pre_rst_line", 0, ser[0], 1'b0);
    chk("pre_rst_act",  0, act[0], 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < N; i++) begin
      chk("rst_serial", i, ser[i], 1'b1);
      chk("rst_active", i, act[i], 1'b0);
      chk("rst_ready",  i, rdy[i], 1'b1);
      chk("rst_done",   i, done[i], 1'b0);
    end
    cmp();
    step(2);
    rst_n = 1'b1;
    clear_trace();
    step(60);
    for (int i = 0; i < N; i++)
      chk("rst_noframe", i, first_low(i), -1);
    clear_trace();
    dv  = 1'b1;
    byt = 8'h3C;
    step();
    dv = 1'b0;
    step(50);
    decode(0, 40);
    chk("post_nfrm", 0, dec_b.size(), 1);
    if (dec_b.size() > 0) chk("post_byte", 0, dec_b[0], 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
